// File: rtl/mvb_tx_sequencer.sv
// Transmit-frame sequencer for the MVB encoder: drives the delimiter generator
// through start delimiter, data and end delimiter, then holds an inter-frame gap.
module mvb_tx_sequencer #(
    parameter int START_LEN = 19,
    parameter int END_LEN   = 4,
    parameter int GAP_LEN   = 8
) (
    input  logic       clk_3M,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_type,
    input  logic [9:0] data_cycles,
    input  logic       abort,
    output logic       send_delimiter,
    output logic [1:0] delimiter_format,
    output logic       data_req,
    output logic [1:0] tx_sel,
    output logic       tx_active,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_END,
        ST_GAP
    } state_t;

    localparam logic [9:0] START_LOAD = 10'(START_LEN - 1);
    localparam logic [9:0] END_LOAD   = 10'(END_LEN - 1);
    localparam logic [9:0] GAP_LOAD   = 10'(GAP_LEN - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] len_q, len_d;
    logic       type_q, type_d;
    logic       abort_pend_q, abort_pend_d;
    logic       done_q, done_d;
    logic [1:0] tx_sel_q;
    logic [1:0] phase;

    always_ff @(posedge clk_3M or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            type_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            tx_sel_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            type_q       <= type_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
            tx_sel_q     <= phase;
        end
    end

    // Delimiter phases always run to completion so the generator index returns to 0;
    // only the data phase can be truncated by abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        type_d       = type_q;
        abort_pend_d = abort_pend_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The frame_done cycle is a dead cycle for new requests.
                if (frame_start && !done_q) begin
                    len_d   = data_cycles;
                    type_d  = frame_type;
                    cnt_d   = START_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                abort_pend_d = abort_pend_q | abort;
                if (cnt_q == 10'd0) begin
                    if (len_q == 10'd0 || abort_pend_q || abort) begin
                        cnt_d   = END_LOAD;
                        state_d = ST_END;
                    end else begin
                        cnt_d   = len_q - 10'd1;
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 10'd0 || abort) begin
                    cnt_d   = END_LOAD;
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            ST_END: begin
                if (cnt_q == 10'd0) begin
                    cnt_d        = GAP_LOAD;
                    abort_pend_d = 1'b0;
                    state_d      = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 10'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from registered state; tx_sel lags phase by one
    // cycle to line up with the delimiter generator's registered output.
    always_comb begin
        send_delimiter   = 1'b0;
        delimiter_format = 2'b00;
        data_req         = 1'b0;
        phase            = 2'b00;
        case (state_q)
            ST_START: begin
                send_delimiter   = 1'b1;
                delimiter_format = type_q ? 2'b10 : 2'b01;
                phase            = 2'b01;
            end
            ST_DATA: begin
                data_req = 1'b1;
                phase    = 2'b10;
            end
            ST_END: begin
                send_delimiter   = 1'b1;
                delimiter_format = 2'b11;
                phase            = 2'b01;
            end
            default: ;
        endcase
    end

    assign tx_sel     = tx_sel_q;
    assign tx_active  = |tx_sel_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_mvb_tx_sequencer.sv
// Self-checking bench for mvb_tx_sequencer: per-cycle expected outputs and the
// stimulus for that cycle are queued together, then drained against the DUT.
module tb_mvb_tx_sequencer;

    localparam int START_LEN = 19;
    localparam int END_LEN   = 4;
    localparam int GAP_LEN   = 8;

    logic       clk_3M = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       frame_type;
    logic [9:0] data_cycles;
    logic       abort;
    logic       send_delimiter;
    logic [1:0] delimiter_format;
    logic       data_req;
    logic [1:0] tx_sel;
    logic       tx_active;
    logic       busy;
    logic       frame_done;

    typedef struct {
        logic [8:0] exp;
        logic       fs;
        logic       ft;
        logic [9:0] dc;
        logic       ab;
    } entry_t;

    entry_t     sb[$];
    logic [1:0] prev_phase;
    int         vectors = 0;
    int         miscompares = 0;

    mvb_tx_sequencer #(
        .START_LEN(START_LEN),
        .END_LEN  (END_LEN),
        .GAP_LEN  (GAP_LEN)
    ) dut (
        .clk_3M          (clk_3M),
        .reset           (reset),
        .frame_start     (frame_start),
        .frame_type      (frame_type),
        .data_cycles     (data_cycles),
        .abort           (abort),
        .send_delimiter  (send_delimiter),
        .delimiter_format(delimiter_format),
        .data_req        (data_req),
        .tx_sel          (tx_sel),
        .tx_active       (tx_active),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk_3M = ~clk_3M;

    function automatic logic [8:0] observe();
        return {send_delimiter, delimiter_format, data_req, tx_sel, tx_active, busy, frame_done};
    endfunction

    task automatic drive(input entry_t e);
        frame_start = e.fs;
        frame_type  = e.ft;
        data_cycles = e.dc;
        abort       = e.ab;
    endtask

    // Expected vector for one cycle; tx_sel is the previous cycle's phase.
    task automatic push_entry(input logic sd, input logic [1:0] fmt, input logic dr,
                              input logic [1:0] ph, input logic bsy, input logic dn,
                              input logic fs, input logic ft, input logic [9:0] dc,
                              input logic ab);
        entry_t e;
        e.exp = {sd, fmt, dr, prev_phase, |prev_phase, bsy, dn};
        e.fs = fs; e.ft = ft; e.dc = dc; e.ab = ab;
        sb.push_back(e);
        prev_phase = ph;
    endtask

    task automatic push_idle(input logic fs, input logic ft, input logic [9:0] dc);
        push_entry(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, fs, ft, dc, 1'b0);
    endtask

    // Whole frame from first START cycle through the frame_done cycle.
    task automatic push_frame(input logic ft, input int n, input int ab_start, input int ab_data,
                              input logic fs_d, input logic ft_d, input logic [9:0] dc_d);
        int ndata;
        ndata = (ab_start != 0) ? 0 : ((ab_data != 0 && ab_data < n) ? ab_data : n);
        for (int i = 1; i <= START_LEN; i++)
            push_entry(1'b1, ft ? 2'b10 : 2'b01, 1'b0, 2'b01, 1'b1, 1'b0,
                       fs_d, ft_d, dc_d, (i == ab_start));
        for (int i = 1; i <= ndata; i++)
            push_entry(1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0,
                       fs_d, ft_d, dc_d, (i == ab_data));
        for (int i = 1; i <= END_LEN; i++)
            push_entry(1'b1, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, fs_d, ft_d, dc_d, 1'b0);
        for (int i = 1; i <= GAP_LEN; i++)
            push_entry(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, fs_d, ft_d, dc_d, 1'b0);
        push_entry(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, fs_d, ft_d, dc_d, 1'b0);
    endtask

    task automatic test_reset();
        logic [8:0] act;
        reset = 1'b0;
        frame_start = 1'b0; frame_type = 1'b0; data_cycles = '0; abort = 1'b0;
        prev_phase = 2'b00;
        repeat (2) @(negedge clk_3M);
        act = observe();
        vectors++;
        if (act !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b expected %b", act, 9'b0);
        end
        reset = 1'b1;
        @(negedge clk_3M);
        act = observe();
        vectors++;
        if (act !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_idle: got %b expected %b", act, 9'b0);
        end
    endtask

    task automatic test_master_n4();
        entry_t     e;
        logic [8:0] act;
        int         idx = 0;
        push_idle(1'b1, 1'b0, 10'd4);
        push_frame(1'b0, 4, 0, 0, 1'b0, 1'b0, 10'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL master_n4 cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
    endtask

    task automatic test_slave_n0();
        entry_t     e;
        logic [8:0] act;
        int         idx = 0;
        push_idle(1'b1, 1'b1, 10'd0);
        push_frame(1'b1, 0, 0, 0, 1'b0, 1'b1, 10'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL slave_n0 cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
    endtask

    task automatic test_abort();
        entry_t     e;
        logic [8:0] act;
        int         idx = 0;
        // START-cycle abort, then a DATA-cycle abort that also proves abort_pend cleared.
        push_idle(1'b1, 1'b0, 10'd8);
        push_frame(1'b0, 8, 5, 0, 1'b0, 1'b0, 10'd0);
        push_idle(1'b1, 1'b0, 10'd16);
        push_frame(1'b0, 16, 0, 3, 1'b0, 1'b0, 10'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL abort cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        entry_t     e;
        logic [8:0] act;
        int         idx = 0;
        // frame_start stays high; type/length inputs change while busy and must be ignored.
        push_idle(1'b1, 1'b1, 10'd3);
        push_frame(1'b1, 3, 0, 0, 1'b1, 1'b0, 10'd9);
        push_idle(1'b1, 1'b0, 10'd2);
        push_frame(1'b0, 2, 0, 0, 1'b0, 1'b1, 10'd7);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
    endtask

    task automatic test_reset_mid_data();
        entry_t     e;
        logic [8:0] act;
        int         idx = 0;
        push_idle(1'b1, 1'b0, 10'd16);
        for (int i = 0; i < START_LEN; i++)
            push_entry(1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            push_entry(1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_data cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
        #1 reset = 1'b0;
        #1 act = observe();
        vectors++;
        if (act !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got %b expected %b", act, 9'b0);
        end
        @(negedge clk_3M);
        reset = 1'b1;
        prev_phase = 2'b00;
        idx = 0;
        push_idle(1'b1, 1'b0, 10'd2);
        push_frame(1'b0, 2, 0, 0, 1'b0, 1'b0, 10'd0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk_3M);
            act = observe();
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("[TB] FAIL after_reset_frame cycle %0d: got %b expected %b", idx, act, e.exp);
            end
            drive(e);
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_master_n4();
        test_slave_n0();
        test_abort();
        test_back_to_back();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mvb_tx_sequencer.md
# mvb_tx_sequencer

Transmit-frame sequencer for the MVB encoder. It accepts a frame request and drives the delimiter generator's `send_delimiter` and `delimiter_format` inputs through three phases: start delimiter, data, end delimiter. It then enforces an inter-frame gap. It also tells the line mux which source (delimiter or Manchester data) owns the line on each clk_3M cycle, and paces the data source with a per-cycle request strobe.

## Interface
- `START_LEN`, 19: cycles `send_delimiter` is held for a master or slave start delimiter. This returns the generator's index to 0.
- `END_LEN`, 4: cycles `send_delimiter` is held for the end delimiter (format 11).
- `GAP_LEN`, 8: idle cycles after the end delimiter before a new frame is accepted (1..255).
- `clk_3M` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `frame_start` in 1: frame request. Sampled only in IDLE.
- `frame_type` in 1: 0 = master frame (format 01), 1 = slave frame (format 10). Latched with `frame_start`.
- `data_cycles` in 10: length of the data phase in clk_3M cycles (0..1023). Latched with `frame_start`. A value of 0 skips the data phase.
- `abort` in 1: truncates the frame. See Operation.
- `send_delimiter` out 1: enable to the delimiter generator.
- `delimiter_format` out 2: 01 master start, 10 slave start, 11 end, 00 otherwise.
- `data_req` out 1: one data half-bit consumed per cycle while high.
- `tx_sel` out 2: line source, aligned to the generator's registered output. 00 none, 01 delimiter, 10 data.
- `tx_active` out 1: high when `tx_sel` != 00.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse on the return to IDLE.

## Operation
- States: IDLE, START, DATA, END, GAP. There is one down-counter `cnt` (10 bits) and one latched abort flag `abort_pend`.
- IDLE: all outputs are 0.
  - If `frame_start`=1: latch `frame_type` and `data_cycles`, load `cnt`=START_LEN-1, go to START.
- START: `send_delimiter`=1 and `delimiter_format`=01 or 10 for exactly START_LEN cycles. When `cnt`=0:
  - If the latched length is 0 or `abort_pend`=1, go to END with `cnt`=END_LEN-1.
  - Otherwise go to DATA with `cnt`=length-1.
- DATA: `data_req`=1, `send_delimiter`=0, `delimiter_format`=00.
  - When `cnt`=0, go to END.
  - If `abort`=1, go to END on the next edge. The current cycle is the last `data_req` cycle.
- END: `send_delimiter`=1, `delimiter_format`=11 for exactly END_LEN cycles, then go to GAP with `cnt`=GAP_LEN-1.
- GAP: all drive outputs are 0. When `cnt`=0, go to IDLE and pulse `frame_done` in the first IDLE cycle. `frame_start` is not sampled in that cycle.
- Delimiter phases are never cut short, so the generator's index always returns to 0.
- `abort` behaviour by state:
  - IDLE, END, GAP: ignored.
  - START: sets `abort_pend` and the data phase is skipped.
  - `abort_pend` clears on entering GAP.
- `frame_start` while `busy`=1: ignored, with no queuing.
- `tx_sel` is `phase` registered once, where `phase` = 01 in START/END, 10 in DATA, 00 otherwise. `tx_active` = |`tx_sel`.
- All outputs and the control signals (`send_delimiter`, `delimiter_format`, `data_req`) are registered, i.e. they are state-decoded from registers.

## Timing
- Reset (async, `reset`=0): state=IDLE, `cnt`=0, `abort_pend`=0. All outputs are 0, including `tx_sel`=00 and `frame_done`=0.
  - Reset mid-frame drops the frame immediately; no end delimiter is sent.
- `frame_start` sampled at edge t: `send_delimiter`=1 from edge t+1, for START_LEN cycles. `tx_sel`=01 from edge t+2.
- Frame length from the first `send_delimiter` to `frame_done`: START_LEN + N + END_LEN + GAP_LEN cycles.
  - With defaults and N=32 this is 63 cycles.
  - The earliest next accepted `frame_start` is the cycle after `frame_done`.
- Phase transitions are back-to-back with no idle cycle: the last START cycle is followed directly by the first DATA or END cycle.
- `data_req` count per frame is exactly N with no abort. With an abort at DATA cycle k (1-based), it is k.

## Test plan
- Master frame, N=4, defaults: `send_delimiter`/01 for 19 cycles → `data_req` 4 cycles → `send_delimiter`/11 for 4 cycles → 8 gap cycles → `frame_done` pulse. `tx_sel` sequence is 01×19, 10×4, 01×4, 00, each lagging its phase by one cycle.
- Slave frame, N=0: `delimiter_format`=10 for 19 cycles, then 11 for 4. `data_req` never asserts and `frame_done` comes 31 cycles after the first `send_delimiter`.
- `abort` in DATA cycle 3 of N=16: `data_req` is high for exactly 3 cycles and the END phase follows immediately. `abort` in START cycle 5: no DATA phase.
- `frame_start` held high continuously: frames start on the cycle after each `frame_done`. A `frame_start` during a busy frame changes neither latched `frame_type` nor length.
- Async `reset` low mid-DATA: all outputs go to 0 without a clock edge. After release, a new `frame_start` produces a full 19-cycle start delimiter.
